vga_scan_gen: RTL and testbench

Raster timing generator and pixel output stage for the 1280x720 VGA/HDMI path. It issues the scan coordinates `vga_x`, `vga_y` and `valid` to the character overlay renderers, and accepts their `r`/`g`/`b`/`valid_px` response a fixed number of cycles later. It delays sync and data-enable by the same amount, so that sync, enable and colour leave the block aligned and registered.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_scan_gen_if.sv | 29 ++
 rtl/sync_delay.sv | 31 +++
 rtl/vga_scan_gen.sv | 120 ++++++++++++
 tb/tb_vga_scan_gen.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Default 720p raster timing constants and coordinate widths shared by the scan generator.
package vga_timing_pkg;

  localparam int unsigned CoordXW = 11;
  localparam int unsigned CoordYW = 10;

  localparam int unsigned DefHActive = 1280;
  localparam int unsigned DefHFp     = 110;
  localparam int unsigned DefHSync   = 40;
  localparam int unsigned DefHBp     = 220;

  localparam int unsigned DefVActive = 720;
  localparam int unsigned DefVFp     = 5;
  localparam int unsigned DefVSync   = 5;
  localparam int unsigned DefVBp     = 20;

  function automatic int unsigned scan_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DefHTotal = scan_total(DefHActive, DefHFp, DefHSync, DefHBp);
  localparam int unsigned DefVTotal = scan_total(DefVActive, DefVFp, DefVSync, DefVBp);

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan coordinate / overlay colour / display output bundle of the scan generator.
interface vga_scan_gen_if;

  logic [vga_timing_pkg::CoordXW-1:0] vga_x;
  logic [vga_timing_pkg::CoordYW-1:0] vga_y;
  logic                               valid;
  logic                               frame_start;
  logic [7:0]                         r;
  logic [7:0]                         g;
  logic [7:0]                         b;
  logic                               valid_px;
  logic                               hsync;
  logic                               vsync;
  logic                               de;
  logic [7:0]                         vga_r;
  logic [7:0]                         vga_g;
  logic [7:0]                         vga_b;

  modport master (
    output vga_x, vga_y, valid, frame_start, hsync, vsync, de, vga_r, vga_g, vga_b,
    input  r, g, b, valid_px
  );

  modport slave (
    input  vga_x, vga_y, valid, frame_start, hsync, vsync, de, vga_r, vga_g, vga_b,
    output r, g, b, valid_px
  );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register with synchronous active-low clear; Depth 0 is a wire.
module sync_delay #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk_i ^ clr_ni;
    assign q_o = d_i;
  end else begin : g_shift
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator with latency-aligned, registered sync/enable/colour output stage.
// Define VGA_TEST_PATTERN_EN to show colour bars on uncovered active pixels.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_FP        = DefHFp,
  parameter int unsigned H_SYNC      = DefHSync,
  parameter int unsigned H_BP        = DefHBp,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned V_FP        = DefVFp,
  parameter int unsigned V_SYNC      = DefVSync,
  parameter int unsigned V_BP        = DefVBp,
  parameter int unsigned PIX_LATENCY = 2,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic           clk,
  input  logic           reset,
  vga_scan_gen_if.master vga
);

  localparam int unsigned HTotal = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CoordXW-1:0] HLast   = CoordXW'(HTotal - 1);
  localparam logic [CoordXW-1:0] HAct    = CoordXW'(H_ACTIVE);
  localparam logic [CoordXW-1:0] HSyncLo = CoordXW'(H_ACTIVE + H_FP);
  localparam logic [CoordXW-1:0] HSyncHi = CoordXW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CoordYW-1:0] VLast   = CoordYW'(VTotal - 1);
  localparam logic [CoordYW-1:0] VAct    = CoordYW'(V_ACTIVE);
  localparam logic [CoordYW-1:0] VSyncLo = CoordYW'(V_ACTIVE + V_FP);
  localparam logic [CoordYW-1:0] VSyncHi = CoordYW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned CtrlW = 6;
`else
  localparam int unsigned CtrlW = 3;
`endif

  logic [CoordXW-1:0] h_cnt_q, h_cnt_d;
  logic [CoordYW-1:0] v_cnt_q, v_cnt_d;
  logic               h_wrap, active, hsync_raw, vsync_raw;
  logic [CtrlW-1:0]   ctrl_raw, ctrl_dly;
  logic               hsync_q, vsync_q, de_q;
  logic [23:0]        color_q, color_d, fill;

  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
  end

  // Reset parks on the last count so the first released edge lands on (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt_q <= HLast;
      v_cnt_q <= VLast;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active    = (h_cnt_q < HAct) && (v_cnt_q < VAct);
  assign hsync_raw = (h_cnt_q >= HSyncLo) && (h_cnt_q < HSyncHi);
  assign vsync_raw = (v_cnt_q >= VSyncLo) && (v_cnt_q < VSyncHi);

`ifdef VGA_TEST_PATTERN_EN
  assign ctrl_raw = {h_cnt_q[9:7], hsync_raw, vsync_raw, active};
`else
  assign ctrl_raw = {hsync_raw, vsync_raw, active};
`endif

  sync_delay #(
    .Width (CtrlW),
    .Depth (PIX_LATENCY)
  ) u_sync_delay (
    .clk_i  (clk),
    .clr_ni (reset),
    .d_i    (ctrl_raw),
    .q_o    (ctrl_dly)
  );

  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    fill = {{8{ctrl_dly[5]}}, {8{ctrl_dly[4]}}, {8{ctrl_dly[3]}}};
`else
    fill = BG_COLOR;
`endif
    color_d = '0;
    if (ctrl_dly[0]) color_d = vga.valid_px ? {vga.r, vga.g, vga.b} : fill;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      color_q <= '0;
    end else begin
      hsync_q <= ctrl_dly[2];
      vsync_q <= ctrl_dly[1];
      de_q    <= ctrl_dly[0];
      color_q <= color_d;
    end
  end

  assign vga.vga_x       = h_cnt_q;
  assign vga.vga_y       = v_cnt_q;
  assign vga.valid       = active;
  assign vga.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.vga_r       = color_q[23:16];
  assign vga.vga_g       = color_q[15:8];
  assign vga.vga_b       = color_q[7:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: a default 720p instance plus a shrunken-timing instance for whole-frame checks.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big;
  logic rst_small;
  int   checks = 0;
  int   errors = 0;

  vga_scan_gen_if big_if ();
  vga_scan_gen_if small_if ();

  vga_scan_gen u_big (
    .clk   (clk),
    .reset (rst_big),
    .vga   (big_if)
  );

  // 17 clocks per line, 9 lines per frame, no pipeline delay, nonzero background.
  vga_scan_gen #(
    .H_ACTIVE    (8),
    .H_FP        (2),
    .H_SYNC      (3),
    .H_BP        (4),
    .V_ACTIVE    (4),
    .V_FP        (1),
    .V_SYNC      (2),
    .V_BP        (2),
    .PIX_LATENCY (0),
    .BG_COLOR    (24'h203040)
  ) u_small (
    .clk   (clk),
    .reset (rst_small),
    .vga   (small_if)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_big_x(input int x);
    int n = 0;
    while (big_if.vga_x !== 11'(x) && n < 4000) begin
      step(1);
      n++;
    end
    if (big_if.vga_x !== 11'(x)) begin
      checks++;
      errors++;
      $display("FAIL wait_big_x: x=%0d never reached, last x=%0d", x, big_if.vga_x);
    end
  endtask

  task automatic wait_small(input int y, input int x);
    int n = 0;
    while ((small_if.vga_y !== 10'(y) || small_if.vga_x !== 11'(x)) && n < 400) begin
      step(1);
      n++;
    end
    if (small_if.vga_y !== 10'(y) || small_if.vga_x !== 11'(x)) begin
      checks++;
      errors++;
      $display("FAIL wait_small: (%0d,%0d) never reached", x, y);
    end
  endtask

  task automatic test_reset();
    rst_big = 1'b0;
    rst_small = 1'b0;
    {big_if.r, big_if.g, big_if.b, big_if.valid_px} = '0;
    {small_if.r, small_if.g, small_if.b, small_if.valid_px} = '0;
    step(3);
    checks++;
    if (big_if.vga_x !== 11'd1649 || big_if.vga_y !== 10'd749) begin
      errors++;
      $display("FAIL reset_coord: got (%0d,%0d) want (1649,749)", big_if.vga_x, big_if.vga_y);
    end
    checks++;
    if ({big_if.valid, big_if.frame_start} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: valid/fs=%b want 00", {big_if.valid, big_if.frame_start});
    end
    checks++;
    if ({big_if.hsync, big_if.vsync, big_if.de} !== 3'b000 ||
        {big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: hs/vs/de=%b rgb=%h want 000 000000",
               {big_if.hsync, big_if.vsync, big_if.de},
               {big_if.vga_r, big_if.vga_g, big_if.vga_b});
    end
    checks++;
    if (small_if.vga_x !== 11'd16 || small_if.vga_y !== 10'd8) begin
      errors++;
      $display("FAIL reset_small_coord: got (%0d,%0d) want (16,8)",
               small_if.vga_x, small_if.vga_y);
    end
    rst_big = 1'b1;
    rst_small = 1'b1;
    step(1);
    checks++;
    if (big_if.vga_x !== 11'd0 || big_if.vga_y !== 10'd0 || big_if.valid !== 1'b1 ||
        big_if.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL release: got (%0d,%0d) valid=%b fs=%b want (0,0) 1 1",
               big_if.vga_x, big_if.vga_y, big_if.valid, big_if.frame_start);
    end
  endtask

  // Walks exactly one small frame from the (0,0) cycle just after release.
  task automatic test_small_frame();
    int   fs_extra = 0, vs_cnt = 0, val_cnt = 0, val_bad = 0, de_bad = 0, col_bad = 0;
    logic prev_valid;
    logic [23:0] exp_col;
    prev_valid = small_if.valid;
    for (int c = 1; c <= 153; c++) begin
      step(1);
      if (small_if.de !== prev_valid) de_bad++;
      exp_col = small_if.de ? 24'h203040 : 24'h0;
      if ({small_if.vga_r, small_if.vga_g, small_if.vga_b} !== exp_col) col_bad++;
      prev_valid = small_if.valid;
      if (small_if.valid === 1'b1) val_cnt++;
      if (small_if.vsync === 1'b1) vs_cnt++;
      if (small_if.valid === 1'b1 && small_if.vga_y >= 10'd4) val_bad++;
      if (c < 153 && small_if.frame_start === 1'b1) fs_extra++;
    end
    checks++;
    if (small_if.frame_start !== 1'b1 || small_if.vga_x !== 11'd0 || small_if.vga_y !== 10'd0)
    begin
      errors++;
      $display("FAIL frame_period: at +153 fs=%b (%0d,%0d) want 1 (0,0)",
               small_if.frame_start, small_if.vga_x, small_if.vga_y);
    end
    checks++;
    if (fs_extra !== 0) begin
      errors++;
      $display("FAIL frame_start_once: extra pulses=%0d want 0", fs_extra);
    end
    checks++;
    if (vs_cnt !== 34) begin
      errors++;
      $display("FAIL vsync_width: high cycles=%0d want 34", vs_cnt);
    end
    checks++;
    if (val_cnt !== 32 || val_bad !== 0) begin
      errors++;
      $display("FAIL valid_region: count=%0d bad=%0d want 32 0", val_cnt, val_bad);
    end
    checks++;
    if (de_bad !== 0) begin
      errors++;
      $display("FAIL de_latency0: misaligned cycles=%0d want 0", de_bad);
    end
    checks++;
    if (col_bad !== 0) begin
      errors++;
      $display("FAIL bg_and_blank: bad colour cycles=%0d want 0", col_bad);
    end
  endtask

  task automatic test_hsync();
    int rise = -1, hi = 0;
    wait_big_x(1390);
    for (int n = 0; n < 50; n++) begin
      if (n > 0) step(1);
      if (big_if.hsync === 1'b1) begin
        hi++;
        if (rise < 0) rise = n;
      end
    end
    checks++;
    if (rise !== 3) begin
      errors++;
      $display("FAIL hsync_rise: rose %0d clocks after x=1390 want 3", rise);
    end
    checks++;
    if (hi !== 40) begin
      errors++;
      $display("FAIL hsync_width: high %0d clocks want 40", hi);
    end
  endtask

  task automatic test_overlay();
    wait_big_x(100);
    step(2);
    big_if.r = 8'hAA;
    big_if.g = 8'h55;
    big_if.b = 8'h11;
    big_if.valid_px = 1'b1;
    checks++;
    if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'h0 || big_if.de !== 1'b1) begin
      errors++;
      $display("FAIL overlay_before: rgb=%h de=%b want 000000 1",
               {big_if.vga_r, big_if.vga_g, big_if.vga_b}, big_if.de);
    end
    step(1);
    {big_if.r, big_if.g, big_if.b, big_if.valid_px} = '0;
    checks++;
    if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'hAA5511 || big_if.de !== 1'b1) begin
      errors++;
      $display("FAIL overlay_hit: rgb=%h de=%b want aa5511 1",
               {big_if.vga_r, big_if.vga_g, big_if.vga_b}, big_if.de);
    end
    step(1);
    checks++;
    if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'h0 || big_if.de !== 1'b1) begin
      errors++;
      $display("FAIL overlay_after: rgb=%h de=%b want 000000 1",
               {big_if.vga_r, big_if.vga_g, big_if.vga_b}, big_if.de);
    end
  endtask

  task automatic test_blanking();
    int bad = 0, de_cnt = 0;
    {big_if.r, big_if.g, big_if.b} = 24'hFFFFFF;
    big_if.valid_px = 1'b1;
    for (int n = 0; n < 1650; n++) begin
      step(1);
      if (big_if.de === 1'b1) begin
        de_cnt++;
        if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'hFFFFFF) bad++;
      end else if (big_if.vga_r !== 8'h00) begin
        bad++;
      end
    end
    {big_if.r, big_if.g, big_if.b, big_if.valid_px} = '0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL blank_colour: bad cycles=%0d want 0", bad);
    end
    checks++;
    if (de_cnt !== 1280) begin
      errors++;
      $display("FAIL de_per_line: de cycles=%0d want 1280", de_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    wait_big_x(500);
    checks++;
    if (big_if.de !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_de: de=%b want 1", big_if.de);
    end
    rst_big = 1'b0;
    step(1);
    checks++;
    if (big_if.vga_x !== 11'd1649 || big_if.vga_y !== 10'd749 || big_if.de !== 1'b0 ||
        big_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: (%0d,%0d) de=%b valid=%b want (1649,749) 0 0",
               big_if.vga_x, big_if.vga_y, big_if.de, big_if.valid);
    end
    rst_big = 1'b1;
    step(1);
    checks++;
    if (big_if.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_fs: fs=%b want 1", big_if.frame_start);
    end
    step(2);
    checks++;
    if (big_if.de !== 1'b0) begin
      errors++;
      $display("FAIL delay_cleared: de=%b two cycles after release want 0", big_if.de);
    end
    step(1);
    checks++;
    if (big_if.de !== 1'b1) begin
      errors++;
      $display("FAIL first_de: de=%b three cycles after release want 1", big_if.de);
    end
    wait_small(2, 5);
    rst_small = 1'b0;
    step(1);
    checks++;
    if (small_if.vga_x !== 11'd16 || small_if.vga_y !== 10'd8 || small_if.de !== 1'b0 ||
        {small_if.vga_r, small_if.vga_g, small_if.vga_b} !== 24'h0) begin
      errors++;
      $display("FAIL small_mid_reset: (%0d,%0d) de=%b rgb=%h want (16,8) 0 000000",
               small_if.vga_x, small_if.vga_y, small_if.de,
               {small_if.vga_r, small_if.vga_g, small_if.vga_b});
    end
    rst_small = 1'b1;
    step(1);
    checks++;
    if (small_if.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL small_release_fs: fs=%b want 1", small_if.frame_start);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    wait_big_x(130);
    step(3);
    checks++;
    if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'h0000FF) begin
      errors++;
      $display("FAIL bar_x130: rgb=%h want 0000ff", {big_if.vga_r, big_if.vga_g, big_if.vga_b});
    end
    wait_big_x(900);
    step(3);
    checks++;
    if ({big_if.vga_r, big_if.vga_g, big_if.vga_b} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL bar_x900: rgb=%h want ffffff", {big_if.vga_r, big_if.vga_g, big_if.vga_b});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_small_frame();
    test_hsync();
    test_overlay();
    test_blanking();
    test_midframe_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
